// File: rtl/chunked_serial_adder_if.sv
// Handshake bundle for chunked_serial_adder: operand channel in, result channel out.
// Pure wiring, no latency of its own.
// The valid/ready pairs carry the backpressure; the master drives operands and out_ready.
// With ADDER_SUB_EN defined the bundle also carries the sub select bit.
interface chunked_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef ADDER_SUB_EN
    logic             sub;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`endif
endinterface

// File: rtl/chunked_serial_adder.sv
// Serial adder: one CHUNK-bit ripple slice reused WIDTH/CHUNK times, carry kept in a register.
// Latency: operands accepted at edge E, result valid from edge E+WIDTH/CHUNK; one op every NCH+2 cycles at best.
// Backpressure: result held stable in DONE until out_ready; in_ready is low for the whole op.
// Optional feature macro ADDER_SUB_EN: adds a sub input that turns the op into a - b (cout=1 means no borrow).
module chunked_serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    chunked_serial_adder_if.slave  adder_if
);

    localparam int NCH   = WIDTH / CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    // Reject shapes the slice schedule cannot cover exactly.
    generate
        if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_err
            $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;

    int                 slice_base;
    logic [CHUNK-1:0]   slice_a;
    logic [CHUNK-1:0]   slice_b;
    logic [CHUNK-1:0]   slice_s;
    logic               slice_c;

    // Pick the operand chunk addressed by the current slice index.
    always_comb begin
        slice_base = int'(idx_q) * CHUNK;
        slice_a    = CHUNK'(a_q >> slice_base);
        slice_b    = CHUNK'(b_q >> slice_base);
    end

    // The shared adder slice: a ripple chain of CHUNK full adders fed by the carry register.
    always_comb begin
        logic c;
        c       = carry_q;
        slice_s = '0;
        for (int i = 0; i < CHUNK; i++) begin
            slice_s[i] = slice_a[i] ^ slice_b[i] ^ c;
            c          = (slice_a[i] & slice_b[i]) | (c & (slice_a[i] ^ slice_b[i]));
        end
        slice_c = c;
    end

    // Next-state: accept in IDLE, walk the slices in RUN, hold the result in DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                // in_ready is high in IDLE, so in_valid alone completes the handshake.
                if (adder_if.in_valid) begin
                    a_d     = adder_if.a;
`ifdef ADDER_SUB_EN
                    // Subtraction is a + ~b + 1; the caller's cin plays no part.
                    b_d     = adder_if.sub ? ~adder_if.b : adder_if.b;
                    carry_d = adder_if.sub ? 1'b1 : adder_if.cin;
`else
                    b_d     = adder_if.b;
                    carry_d = adder_if.cin;
`endif
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[slice_base +: CHUNK] = slice_s;
                carry_d                    = slice_c;
                idx_d                      = idx_q + 1'b1;
                if (idx_q == IDX_W'(NCH - 1)) begin
                    cout_d  = slice_c;
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (adder_if.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    // Handshake flags decode from state only, so no input reaches them combinationally.
    assign adder_if.in_ready  = (state_q == S_IDLE);
    assign adder_if.out_valid = (state_q == S_DONE);
    assign adder_if.busy      = (state_q != S_IDLE);
    assign adder_if.sum       = sum_q;
    assign adder_if.cout      = cout_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: three instances (8/2, 8/8, 3/1) driven from shared arrays.
// A transaction-level model predicts handshake flags and results every cycle.
// Directed cases pin the model and the boundary shapes; random ops cover the rest.
module tb_chunked_serial_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    chunked_serial_adder_if #(.WIDTH(8)) u_if0 ();
    chunked_serial_adder_if #(.WIDTH(8)) u_if1 ();
    chunked_serial_adder_if #(.WIDTH(3)) u_if2 ();

    chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) dut0 (.clk(clk), .rst_n(rst_n), .adder_if(u_if0));
    chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) dut1 (.clk(clk), .rst_n(rst_n), .adder_if(u_if1));
    chunked_serial_adder #(.WIDTH(3), .CHUNK(1)) dut2 (.clk(clk), .rst_n(rst_n), .adder_if(u_if2));

    // Drive side
    logic       dr_iv  [3];
    logic [7:0] dr_a   [3];
    logic [7:0] dr_b   [3];
    logic       dr_cin [3];
    logic       dr_sub [3];
    logic       dr_or  [3];
    // Observe side
    logic [7:0] d_sum  [3];
    logic       d_cout [3];
    logic       d_ir   [3];
    logic       d_ov   [3];
    logic       d_busy [3];

    assign u_if0.in_valid = dr_iv[0];   assign u_if1.in_valid = dr_iv[1];   assign u_if2.in_valid = dr_iv[2];
    assign u_if0.a = dr_a[0];           assign u_if1.a = dr_a[1];           assign u_if2.a = dr_a[2][2:0];
    assign u_if0.b = dr_b[0];           assign u_if1.b = dr_b[1];           assign u_if2.b = dr_b[2][2:0];
    assign u_if0.cin = dr_cin[0];       assign u_if1.cin = dr_cin[1];       assign u_if2.cin = dr_cin[2];
    assign u_if0.out_ready = dr_or[0];  assign u_if1.out_ready = dr_or[1];  assign u_if2.out_ready = dr_or[2];
`ifdef ADDER_SUB_EN
    assign u_if0.sub = dr_sub[0];       assign u_if1.sub = dr_sub[1];       assign u_if2.sub = dr_sub[2];
`endif
    assign d_sum[0] = u_if0.sum;        assign d_sum[1] = u_if1.sum;        assign d_sum[2] = {5'b0, u_if2.sum};
    assign d_cout[0] = u_if0.cout;      assign d_cout[1] = u_if1.cout;      assign d_cout[2] = u_if2.cout;
    assign d_ir[0] = u_if0.in_ready;    assign d_ir[1] = u_if1.in_ready;    assign d_ir[2] = u_if2.in_ready;
    assign d_ov[0] = u_if0.out_valid;   assign d_ov[1] = u_if1.out_valid;   assign d_ov[2] = u_if2.out_valid;
    assign d_busy[0] = u_if0.busy;      assign d_busy[1] = u_if1.busy;      assign d_busy[2] = u_if2.busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int nch_of(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int w_of(input int k);
        return (k == 2) ? 3 : 8;
    endfunction

    // Reference result {cout, sum} from plain arithmetic on the instance width.
    function automatic logic [8:0] exp_res(input int k, input logic [7:0] a, input logic [7:0] b,
                                           input logic cin, input logic sub);
        int unsigned m, av, bv, t;
        logic [8:0]  r;
        m  = (32'd1 << w_of(k)) - 32'd1;
        av = 32'(a) & m;
        bv = 32'(b) & m;
        if (sub) begin
            t    = (av - bv) & m;
            r[8] = (av >= bv);
        end else begin
            t    = av + bv + 32'(cin);
            r[8] = ((t >> w_of(k)) & 32'd1) != 0;
        end
        r[7:0] = 8'(t & m);
        return r;
    endfunction

    // Transaction model: op in flight, cycles since accept, expected result.
    logic       m_busy [3];
    int         m_cnt  [3];
    logic [8:0] m_res  [3];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_busy[k] <= 1'b0;
                m_cnt[k]  <= 0;
            end else if (!m_busy[k]) begin
                if (dr_iv[k]) begin
                    m_busy[k] <= 1'b1;
                    m_cnt[k]  <= 0;
                    m_res[k]  <= exp_res(k, dr_a[k], dr_b[k], dr_cin[k], dr_sub[k]);
                end
            end else if (m_cnt[k] >= nch_of(k)) begin
                if (dr_or[k]) m_busy[k] <= 1'b0;
            end else begin
                m_cnt[k] <= m_cnt[k] + 1;
            end
        end
    end

    // Per-cycle comparison of every instance against the model.
    logic ov_exp;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                ov_exp = m_busy[k] && (m_cnt[k] >= nch_of(k));
                chk($sformatf("in_ready[%0d]", k), 32'(d_ir[k]), 32'(!m_busy[k]));
                chk($sformatf("out_valid[%0d]", k), 32'(d_ov[k]), 32'(ov_exp));
                chk($sformatf("busy[%0d]", k), 32'(d_busy[k]), 32'(m_busy[k]));
                if (ov_exp)
                    chk($sformatf("result[%0d]", k), 32'({d_cout[k], d_sum[k]}), 32'(m_res[k]));
            end
        end
    end

    // One complete op on instance k; called #1 after a rising edge with the instance idle.
    task automatic do_op(input int k, input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sub, input int hold, input bit gap, output logic [8:0] res);
        int lat;
        if (gap) begin
            @(posedge clk); #1;
        end
        chk($sformatf("ready_before_op[%0d]", k), 32'(d_ir[k]), 32'd1);
        dr_a[k] = a; dr_b[k] = b; dr_cin[k] = cin; dr_sub[k] = sub;
        dr_iv[k] = 1'b1;
        dr_or[k] = (hold == 0);
        @(posedge clk); #1;
        // Operands are latched; scribble on the inputs to show they are ignored now.
        lat = 0;
        do begin
            dr_iv[k] = 1'($urandom); dr_a[k] = 8'($urandom); dr_b[k] = 8'($urandom);
            dr_cin[k] = 1'($urandom);
`ifdef ADDER_SUB_EN
            dr_sub[k] = 1'($urandom);
`endif
            @(posedge clk); #1;
            lat++;
        end while (!d_ov[k] && lat < 40);
        dr_iv[k] = 1'b0;
        chk($sformatf("latency[%0d]", k), 32'(lat), 32'(nch_of(k)));
        res = {d_cout[k], d_sum[k]};
        for (int i = 0; i < hold; i++) begin
            dr_iv[k] = 1'($urandom); dr_a[k] = 8'($urandom); dr_b[k] = 8'($urandom);
            @(posedge clk); #1;
            dr_iv[k] = 1'b0;
            chk($sformatf("hold_stable[%0d]", k), 32'({d_cout[k], d_sum[k]}), 32'(res));
            chk($sformatf("hold_valid[%0d]", k), 32'(d_ov[k]), 32'd1);
            chk($sformatf("hold_not_ready[%0d]", k), 32'(d_ir[k]), 32'd0);
        end
        dr_or[k] = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("idle_after_ack[%0d]", k), 32'(d_ir[k]), 32'd1);
        dr_or[k] = 1'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    logic [8:0] res;
    logic [8:0] e9;
    logic [7:0] ra, rb;
    logic       rc, rs;
    int         rk;

    initial begin
        for (int k = 0; k < 3; k++) begin
            dr_iv[k] = 0; dr_a[k] = 0; dr_b[k] = 0; dr_cin[k] = 0; dr_sub[k] = 0; dr_or[k] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_sum[%0d]", k), 32'({d_cout[k], d_sum[k]}), 32'd0);
            chk($sformatf("reset_ready[%0d]", k), 32'(d_ir[k]), 32'd1);
            chk($sformatf("reset_valid[%0d]", k), 32'(d_ov[k]), 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Hand-computed anchors for the model itself.
        chk("model_ff_01", 32'(exp_res(0, 8'hFF, 8'h01, 1'b0, 1'b0)), 32'h100);
        chk("model_3bit_111", 32'(exp_res(2, 8'h01, 8'h01, 1'b1, 1'b0)), 32'h003);
        chk("model_sub_5_7", 32'(exp_res(0, 8'h05, 8'h07, 1'b0, 1'b1)), 32'h0FE);

        // Full-adder truth table on the 1-bit-slice 3-bit instance.
        for (int i = 0; i < 16; i++) begin
            e9 = 9'(i & 1) + 9'((i >> 1) & 1) + 9'((i >> 2) & 1);
            do_op(2, 8'(i & 1), 8'((i >> 1) & 1), 1'((i >> 2) & 1), 1'b0, (i >> 3) & 1, 1'b0, res);
            chk("fa_truth", 32'(res), 32'(e9));
        end
        do_op(2, 8'h01, 8'h01, 1'b1, 1'b0, 0, 1'b1, res);
        chk("fa_1_1_1", 32'(res), 32'h003);

        // Full carry ripple through all four slices.
        do_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b1, res);
        chk("ff_plus_01", 32'(res), 32'h100);

        // Long backpressure.
        do_op(0, 8'h3C, 8'h5A, 1'b0, 1'b0, 10, 1'b0, res);
        chk("backpressure", 32'(res), 32'h096);

        // Single-slice instance.
        do_op(1, 8'h80, 8'h80, 1'b1, 1'b0, 0, 1'b1, res);
        chk("chunk_eq_width", 32'(res), 32'h101);

        // Reset two slices into an op.
        @(posedge clk); #1;
        dr_a[0] = 8'hAB; dr_b[0] = 8'hCD; dr_cin[0] = 1'b1; dr_iv[0] = 1'b1; dr_or[0] = 1'b1;
        @(posedge clk); #1;
        dr_iv[0] = 1'b0;
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_sum", 32'({d_cout[0], d_sum[0]}), 32'd0);
        chk("midrst_valid", 32'(d_ov[0]), 32'd0);
        chk("midrst_ready", 32'(d_ir[0]), 32'd1);
        chk("midrst_busy", 32'(d_busy[0]), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(0, 8'h10, 8'h20, 1'b0, 1'b0, 0, 1'b0, res);
        chk("after_reset_op", 32'(res), 32'h030);

`ifdef ADDER_SUB_EN
        do_op(0, 8'h05, 8'h07, 1'b1, 1'b1, 0, 1'b1, res);
        chk("sub_borrow", 32'(res), 32'h0FE);
        do_op(0, 8'h07, 8'h05, 1'b0, 1'b1, 1, 1'b1, res);
        chk("sub_no_borrow", 32'(res), 32'h102);
`endif

        // Random ops across all instances, back-to-back or spaced, with random hold.
        for (int n = 0; n < 150; n++) begin
            rk = $urandom_range(0, 2);
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
`ifdef ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            do_op(rk, ra, rb, rc, rs, $urandom_range(0, 3), 1'($urandom), res);
            chk("rand_result", 32'(res), 32'(exp_res(rk, ra, rb, rc, rs)));
        end

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
